spiflash_rdctrl: RTL

//  Read-only SPI NOR flash controller. Turns 32-bit word reads from a CPU-side valid/ready
//  bus into SPI mode-0 transactions. After reset it issues power-up (0xAB), then serves each

---
 rtl/spiflash_pkg.sv | 32 +++
 rtl/spiflash_shift.sv | 68 ++++++
 rtl/spiflash_rdctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spiflash_pkg.sv
// Shared constants, FSM state encoding and helpers for the SPI flash read controller.
package spiflash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PWRUP = 8'hAB;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int WORD_BITS = 32;

  typedef enum logic [3:0] {
    ST_RST_CS   = 4'd0,
    ST_PWR_CMD  = 4'd1,
    ST_PWR_WAIT = 4'd2,
    ST_IDLE     = 4'd3,
    ST_RD_CMD   = 4'd4,
    ST_RD_ADDR  = 4'd5,
    ST_RD_DATA  = 4'd6,
    ST_CS_GAP   = 4'd7
`ifdef SPIFLASH_RDCTRL_CONT_EN
    ,
    ST_CONT     = 4'd8
`endif
  } state_t;

  // Bytes arrive in address order, MSB-first within the shift register;
  // the bus wants the first byte in the least significant lane.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spiflash_shift.sv
// SPI mode-0 bit engine: shifts N bits out on mosi (MSB first) and samples
// miso on the cycle that raises sclk. Each bit is CLKDIV cycles with sclk low
// followed by CLKDIV cycles with sclk high. A start issued on the cycle that
// done is high continues seamlessly into the next field.
module spiflash_shift
  import spiflash_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  nbits,
  input  logic [31:0] tx_data,
  input  logic        spi_miso,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  localparam logic [15:0] DIV_LOAD = 16'(CLKDIV - 1);

  logic        active;
  logic [15:0] div_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sh;
  logic [31:0] rx_sh;

  assign done     = active && spi_sclk && (div_cnt == '0) && (bit_cnt == '0);
  assign spi_mosi = tx_sh[31];
  assign rx_data  = rx_sh;

  // Half-period timer, bit counter and the two shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      spi_sclk <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      div_cnt  <= DIV_LOAD;
      bit_cnt  <= nbits - 6'd1;
      tx_sh    <= tx_data;
      spi_sclk <= 1'b0;
    end else if (active) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - 16'd1;
      end else begin
        div_cnt <= DIV_LOAD;
        if (!spi_sclk) begin
          spi_sclk <= 1'b1;
          rx_sh    <= {rx_sh[30:0], spi_miso};
        end else begin
          // mosi moves on the falling edge so it is stable while sclk is high
          spi_sclk <= 1'b0;
          tx_sh    <= {tx_sh[30:0], 1'b0};
          if (bit_cnt == '0) active <= 1'b0;
          else               bit_cnt <= bit_cnt - 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spiflash_rdctrl.sv
// Read-only SPI NOR flash controller: powers the flash up with 0xAB, then
// serves 32-bit word reads with READ (0x03) + 24-bit address + 4 data bytes.
// Optional build macro SPIFLASH_RDCTRL_CONT_EN keeps cs low after a read so a
// following sequential word costs only the 32 data bits.
//
//  state       | meaning
//  ------------+---------------------------------------------------------
//  RST_CS      | cs high for CS_HIGH cycles after reset
//  PWR_CMD     | cs low, shifting the 0xAB power-up command
//  PWR_WAIT    | cs high, waiting PWRUP_WAIT cycles for the flash to wake
//  IDLE        | ready for a request, pins quiet
//  RD_CMD      | shifting READ opcode
//  RD_ADDR     | shifting 24-bit word address
//  RD_DATA     | receiving 4 data bytes
//  CS_GAP      | ready cycle (cs low) then cs high for CS_HIGH cycles
//  CONT        | (continuous build) cs held low, flash positioned at next word
module spiflash_rdctrl
  import spiflash_pkg::*;
#(
  parameter int CLKDIV     = 2,
  parameter int CS_HIGH    = 4,
  parameter int PWRUP_WAIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [23:0] addr,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_t      state;
  logic [15:0] cnt;
  logic [23:0] addr_q;
  logic [23:0] req_word;
  logic        accept;

  logic        sh_start;
  logic [5:0]  sh_nbits;
  logic [31:0] sh_tx;
  logic        sh_done;
  logic [31:0] sh_rx;

`ifdef SPIFLASH_RDCTRL_CONT_EN
  logic        pend;
  logic [23:0] next_word;
  logic        seq_hit;

  assign next_word = addr_q + 24'd4;
  assign seq_hit   = (req_word == next_word);
`endif

  assign req_word = addr & 24'hFFFFFC;

  assign busy = (state != ST_IDLE)
`ifdef SPIFLASH_RDCTRL_CONT_EN
                && (state != ST_CONT)
`endif
                ;

  spiflash_shift #(
    .CLKDIV (CLKDIV)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .start    (sh_start),
    .nbits    (sh_nbits),
    .tx_data  (sh_tx),
    .spi_miso (spi_miso),
    .done     (sh_done),
    .rx_data  (sh_rx),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi)
  );

  // Bit-engine launches and request acceptance, chained so fields run back to back.
  always_comb begin
    sh_start = 1'b0;
    sh_nbits = 6'(CMD_BITS);
    sh_tx    = {CMD_READ, 24'h000000};
    accept   = 1'b0;
    case (state)
      ST_RST_CS: begin
        if (cnt == '0) begin
          sh_start = 1'b1;
          sh_tx    = {CMD_PWRUP, 24'h000000};
        end
      end
      ST_IDLE: begin
        if (valid) begin
          accept   = 1'b1;
          sh_start = 1'b1;
        end
      end
      ST_RD_CMD: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_nbits = 6'(ADDR_BITS);
          sh_tx    = {addr_q, 8'h00};
        end
      end
      ST_RD_ADDR: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_nbits = 6'(WORD_BITS);
          sh_tx    = '0;
        end
      end
`ifdef SPIFLASH_RDCTRL_CONT_EN
      ST_CS_GAP: begin
        if ((cnt == '0) && pend) sh_start = 1'b1;
      end
      ST_CONT: begin
        // the request that just completed still holds valid during its ready cycle
        if (valid && !ready) begin
          accept = 1'b1;
          if (seq_hit) begin
            sh_start = 1'b1;
            sh_nbits = 6'(WORD_BITS);
            sh_tx    = '0;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Sequencer: state, cs, down-counter timer, captured address and bus response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RST_CS;
      cnt    <= 16'(CS_HIGH - 1);
      spi_cs <= 1'b1;
      ready  <= 1'b0;
      rdata  <= '0;
      addr_q <= '0;
`ifdef SPIFLASH_RDCTRL_CONT_EN
      pend   <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        ST_RST_CS: begin
          if (cnt == '0) begin
            spi_cs <= 1'b0;
            state  <= ST_PWR_CMD;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_PWR_CMD: begin
          if (sh_done) begin
            spi_cs <= 1'b1;
            cnt    <= 16'(PWRUP_WAIT - 1);
            state  <= ST_PWR_WAIT;
          end
        end
        ST_PWR_WAIT: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 16'd1;
        end
        ST_IDLE: begin
          if (accept) begin
            spi_cs <= 1'b0;
            addr_q <= req_word;
            state  <= ST_RD_CMD;
          end
        end
        ST_RD_CMD: begin
          if (sh_done) state <= ST_RD_ADDR;
        end
        ST_RD_ADDR: begin
          if (sh_done) state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (sh_done) begin
            ready <= 1'b1;
            rdata <= byte_swap(sh_rx);
`ifdef SPIFLASH_RDCTRL_CONT_EN
            state <= ST_CONT;
`else
            // one extra count covers the ready cycle, which keeps cs low
            cnt   <= 16'(CS_HIGH);
            state <= ST_CS_GAP;
`endif
          end
        end
        ST_CS_GAP: begin
          if (cnt != '0) begin
            spi_cs <= 1'b1;
            cnt    <= cnt - 16'd1;
          end
`ifdef SPIFLASH_RDCTRL_CONT_EN
          else if (pend) begin
            pend   <= 1'b0;
            spi_cs <= 1'b0;
            state  <= ST_RD_CMD;
          end
`endif
          else begin
            state <= ST_IDLE;
          end
        end
`ifdef SPIFLASH_RDCTRL_CONT_EN
        ST_CONT: begin
          if (accept) begin
            addr_q <= req_word;
            if (seq_hit) begin
              state <= ST_RD_DATA;
            end else begin
              spi_cs <= 1'b1;
              cnt    <= 16'(CS_HIGH - 1);
              pend   <= 1'b1;
              state  <= ST_CS_GAP;
            end
          end
        end
`endif
        default: state <= ST_RST_CS;
      endcase
    end
  end

endmodule
